// File: rtl/sample_feeder.sv
// sample_feeder: circular sample FIFO that feeds the DFT operation manager.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   inSample        signed input sample, qualified by the inValid strobe
//   sampleReady     at least one sample is buffered
//   newSample       oldest buffered sample; consumed by the writeSample pop strobe
//   clearOverflow   clears overflow and droppedCount
//   count           number of buffered samples
//   overflow        sticky drop flag
//   droppedCount    saturating count of dropped samples
module sample_feeder #(
    parameter int N     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [N-1:0]        inSample,
    input  logic                       inValid,
    output logic                       sampleReady,
    output logic signed [N-1:0]        newSample,
    input  logic                       writeSample,
    input  logic                       clearOverflow,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 droppedCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } fill_state_t;

    logic signed [N-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    dropped_q, dropped_d;
    fill_state_t   state_q, state_d;

    logic push;
    logic pop;
    logic drop;

    // A pop while empty is ignored; a push into a full buffer is
    // only allowed when a pop frees the head slot in the same cycle.
    assign pop  = writeSample && (state_q != ST_EMPTY);
    assign push = inValid && ((state_q != ST_FULL) || pop);
    assign drop = inValid && !push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = ST_PARTIAL;
        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d == FULL_CNT) begin
            state_d = ST_FULL;
        end
    end

    // A drop in the same cycle as a clear wins, restarting the count at 1.
    always_comb begin
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clearOverflow) begin
                dropped_d = 8'd1;
            end else if (dropped_q != 8'hFF) begin
                dropped_d = dropped_q + 8'd1;
            end
        end else if (clearOverflow) begin
            overflow_d = 1'b0;
            dropped_d  = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= 8'd0;
            state_q    <= ST_EMPTY;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            state_q    <= state_d;
        end
    end

    // Sample storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= inSample;
        end
    end

    assign newSample    = mem[rd_ptr_q];
    assign sampleReady  = (state_q != ST_EMPTY);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign droppedCount = dropped_q;

endmodule

// File: tb/tb_sample_feeder.sv
// tb_sample_feeder: directed self-checking bench for sample_feeder.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_sample_feeder;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] inSample;
    logic               inValid;
    logic               sampleReady;
    logic signed [15:0] newSample;
    logic               writeSample;
    logic               clearOverflow;
    logic [3:0]         count;
    logic               overflow;
    logic [7:0]         droppedCount;

    int total = 0;
    int bad   = 0;

    sample_feeder #(.N(16), .DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .inSample     (inSample),
        .inValid      (inValid),
        .sampleReady  (sampleReady),
        .newSample    (newSample),
        .writeSample  (writeSample),
        .clearOverflow(clearOverflow),
        .count        (count),
        .overflow     (overflow),
        .droppedCount (droppedCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        total++;
        if (sampleReady !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%0b want=0", sampleReady);
        end
        total++;
        if (count !== 4'd0) begin
            bad++;
            $display("FAIL reset_count got=%0d want=0", count);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf got=%0b want=0", overflow);
        end
        total++;
        if (droppedCount !== 8'd0) begin
            bad++;
            $display("FAIL reset_drop got=%0d want=0", droppedCount);
        end
        writeSample = 1'b1;
        tick();
        writeSample = 1'b0;
        total++;
        if (count !== 4'd0 || sampleReady !== 1'b0) begin
            bad++;
            $display("FAIL empty_pop count=%0d ready=%0b want 0/0",
                     count, sampleReady);
        end
    endtask

    task automatic test_order();
        logic signed [15:0] exp [3];
        exp[0] = 16'sd100;
        exp[1] = 16'sd222;
        exp[2] = -16'sd333;
        inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inSample = exp[i];
            tick();
        end
        inValid = 1'b0;
        total++;
        if (count !== 4'd3 || newSample !== 16'sd100) begin
            bad++;
            $display("FAIL order_fill count=%0d head=%0d want 3/100",
                     count, newSample);
        end
        writeSample = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (newSample !== exp[i]) begin
                bad++;
                $display("FAIL order_pop%0d got=%0d want=%0d",
                         i, newSample, exp[i]);
            end
            tick();
        end
        writeSample = 1'b0;
        total++;
        if (sampleReady !== 1'b0 || count !== 4'd0) begin
            bad++;
            $display("FAIL order_empty ready=%0b count=%0d want 0/0",
                     sampleReady, count);
        end
    endtask

    task automatic test_full_drop();
        inValid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            inSample = 16'(i);
            tick();
        end
        inValid = 1'b0;
        total++;
        if (count !== 4'd8 || overflow !== 1'b1 || droppedCount !== 8'd1) begin
            bad++;
            $display("FAIL full_drop count=%0d ovf=%0b drop=%0d want 8/1/1",
                     count, overflow, droppedCount);
        end
        writeSample = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total++;
            if (newSample !== 16'(i)) begin
                bad++;
                $display("FAIL full_pop%0d got=%0d want=%0d",
                         i, newSample, i);
            end
            tick();
        end
        writeSample = 1'b0;
        total++;
        if (sampleReady !== 1'b0) begin
            bad++;
            $display("FAIL full_empty got=%0b want=0", sampleReady);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] want;
        inValid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            inSample = 16'(i);
            tick();
        end
        inSample    = 16'sd50;
        writeSample = 1'b1;
        #1;
        total++;
        if (newSample !== 16'sd1) begin
            bad++;
            $display("FAIL simul_head got=%0d want=1", newSample);
        end
        tick();
        inValid = 1'b0;
        total++;
        if (count !== 4'd8 || droppedCount !== 8'd1) begin
            bad++;
            $display("FAIL simul_full count=%0d drop=%0d want 8/1",
                     count, droppedCount);
        end
        for (int i = 2; i <= 9; i++) begin
            want = (i == 9) ? 16'sd50 : 16'(i);
            total++;
            if (newSample !== want) begin
                bad++;
                $display("FAIL wrap_pop%0d got=%0d want=%0d",
                         i, newSample, want);
            end
            tick();
        end
        writeSample = 1'b0;
        total++;
        if (count !== 4'd0) begin
            bad++;
            $display("FAIL wrap_empty got=%0d want=0", count);
        end
    endtask

    task automatic test_overflow();
        inValid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            inSample = 16'(10 + i);
            tick();
        end
        total++;
        if (droppedCount !== 8'd2) begin
            bad++;
            $display("FAIL ovf_pre got=%0d want=2", droppedCount);
        end
        clearOverflow = 1'b1;
        tick();
        inValid = 1'b0;
        total++;
        if (overflow !== 1'b1 || droppedCount !== 8'd1) begin
            bad++;
            $display("FAIL clr_drop ovf=%0b drop=%0d want 1/1",
                     overflow, droppedCount);
        end
        tick();
        clearOverflow = 1'b0;
        total++;
        if (overflow !== 1'b0 || droppedCount !== 8'd0) begin
            bad++;
            $display("FAIL clr_only ovf=%0b drop=%0d want 0/0",
                     overflow, droppedCount);
        end
        inValid = 1'b1;
        repeat (254) tick();
        total++;
        if (droppedCount !== 8'd254) begin
            bad++;
            $display("FAIL sat_254 got=%0d want=254", droppedCount);
        end
        repeat (46) tick();
        inValid = 1'b0;
        total++;
        if (droppedCount !== 8'd255 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL sat_255 drop=%0d ovf=%0b want 255/1",
                     droppedCount, overflow);
        end
        total++;
        if (count !== 4'd8 || newSample !== 16'sd10) begin
            bad++;
            $display("FAIL sat_intact count=%0d head=%0d want 8/10",
                     count, newSample);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        inValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inSample = 16'(20 + i);
            tick();
        end
        inValid = 1'b0;
        total++;
        if (count !== 4'd4) begin
            bad++;
            $display("FAIL mid_fill got=%0d want=4", count);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (count !== 4'd0 || sampleReady !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst count=%0d ready=%0b want 0/0",
                     count, sampleReady);
        end
        #1;
        rst = 1'b0;
        tick();
        inValid  = 1'b1;
        inSample = 16'sd77;
        tick();
        inValid = 1'b0;
        total++;
        if (newSample !== 16'sd77 || count !== 4'd1 || sampleReady !== 1'b1) begin
            bad++;
            $display("FAIL mid_push head=%0d count=%0d ready=%0b want 77/1/1",
                     newSample, count, sampleReady);
        end
    endtask

    initial begin
        rst           = 1'b1;
        inSample      = '0;
        inValid       = 1'b0;
        writeSample   = 1'b0;
        clearOverflow = 1'b0;
        #1;
        test_reset();
        test_order();
        test_full_drop();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
